beam_meta_capture: RTL and testbench

Receive-side counterpart to the beam metadata builder. It takes the aligned trigger strobe and 8-bit beam metadata, stamps each accepted trigger with a free-running timestamp, and applies a retrigger holdoff. Accepted records go into a small FIFO, which the readout logic drains over a valid/ready stream. It sits between the trigger/metadata path and the SURF event readout.

---
 rtl/beam_meta_pkg.sv | 18 +
 rtl/beam_meta_capture_if.sv | 21 ++
 rtl/beam_meta_fifo.sv | 68 ++++++
 rtl/beam_meta_capture.sv | 113 +++++++++++
 tb/tb_beam_meta_capture.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/beam_meta_pkg.sv
// Shared types and widths for the beam metadata capture block.
package beam_meta_pkg;

  localparam int unsigned META_BITS   = 8;
  localparam int unsigned TS_MAX_BITS = 24;
  localparam int unsigned REC_BITS    = 32;

  typedef struct packed {
    logic [META_BITS-1:0]   meta;
    logic [TS_MAX_BITS-1:0] ts;
  } meta_rec_t;

  typedef enum logic [0:0] {
    IDLE,
    HOLD
  } holdoff_state_t;

endpackage

// File: rtl/beam_meta_capture_if.sv
// Record readout stream (valid/ready) between capture and event readout.
interface beam_meta_capture_if;
  import beam_meta_pkg::*;

  logic [REC_BITS-1:0] m_tdata;
  logic                m_tvalid;
  logic                m_tready;

  modport master (
    output m_tdata,
    output m_tvalid,
    input  m_tready
  );

  modport slave (
    input  m_tdata,
    input  m_tvalid,
    output m_tready
  );

endinterface

// File: rtl/beam_meta_fifo.sv
// Single-clock record FIFO with a registered first-word-fall-through head.
module beam_meta_fifo
  import beam_meta_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_en,
  input  logic [REC_BITS-1:0] wr_data,
  input  logic                rd_en,
  output logic [REC_BITS-1:0] rd_data,
  output logic                valid,
  output logic                full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [REC_BITS-1:0] mem [DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PW-1:0]       wr_ptr_d, rd_ptr_d;
  logic                push_c, pop_c;
  logic [REC_BITS-1:0] head_c;
  logic                empty_d, full_d;

  // Pointer advance; push uses last cycle's full so a same-cycle pop never frees room.
  always_comb begin
    push_c   = wr_en & ~full;
    pop_c    = rd_en & valid;
    wr_ptr_d = wr_ptr_q + PW'(push_c);
    rd_ptr_d = rd_ptr_q + PW'(pop_c);
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    // The next head bypasses storage when it is the word being written now.
    if (push_c && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
      head_c = wr_data;
    end else begin
      head_c = mem[rd_ptr_d[AW-1:0]];
    end
  end

  // Record storage (data only, no reset needed).
  always_ff @(posedge clk_i) begin
    if (push_c) begin
      mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  // Pointers, flags and output head register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rd_data  <= '0;
      valid    <= 1'b0;
      full     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rd_data  <= head_c;
      valid    <= ~empty_d;
      full     <= full_d;
    end
  end

endmodule

// File: rtl/beam_meta_capture.sv
// Timestamps accepted triggers with beam metadata, applies retrigger holdoff,
// and queues records for readout. Define BEAM_META_CAPTURE_DROPS_EN to build
// the saturating dropped-trigger counter and its drop_count_o port.
module beam_meta_capture
  import beam_meta_pkg::*;
#(
  parameter int unsigned TS_BITS = 24,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned HOLDOFF = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 run_i,
  input  logic                 trig_i,
  input  logic [META_BITS-1:0] meta_i,
  beam_meta_capture_if.master  m,
  output logic                 full_o
`ifdef BEAM_META_CAPTURE_DROPS_EN
  ,
  output logic [15:0]          drop_count_o
`endif
);

  localparam int unsigned HCNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  holdoff_state_t    state_q, state_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [TS_BITS-1:0] ts_q;
  logic              accept_c;
  logic              push_c;
  meta_rec_t         rec_c;

  // Free-running timestamp, wraps naturally at 2^TS_BITS.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_BITS'(1);
    end
  end

  // Holdoff state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // Holdoff next-state: a trigger taken in IDLE starts holdoff whether or not it fits.
  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    accept_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trig_i && run_i) begin
          accept_c = 1'b1;
          if (HOLDOFF != 0) begin
            state_d = HOLD;
            hcnt_d  = HCNT_W'(HOLDOFF - 1);
          end
        end
      end
      HOLD: begin
        if (hcnt_q == '0) begin
          state_d = IDLE;
        end else begin
          hcnt_d = hcnt_q - HCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Record assembly; timestamp zero-extended to the full record field.
  always_comb begin
    push_c     = accept_c & ~full_o;
    rec_c.meta = meta_i;
    rec_c.ts   = TS_MAX_BITS'(ts_q);
  end

  beam_meta_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en   (push_c),
    .wr_data (rec_c),
    .rd_en   (m.m_tready),
    .rd_data (m.m_tdata),
    .valid   (m.m_tvalid),
    .full    (full_o)
  );

`ifdef BEAM_META_CAPTURE_DROPS_EN
  logic drop_c;
  assign drop_c = accept_c & full_o;

  // Saturating count of triggers lost to a full FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_count_o <= '0;
    end else if (drop_c && (drop_count_o != 16'hFFFF)) begin
      drop_count_o <= drop_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_beam_meta_capture.sv
// Directed bench: instance A (24-bit ts, holdoff 8), instance B (8-bit ts, no holdoff).
module tb_beam_meta_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       trig_a = 1'b0, trig_b = 1'b0;
  logic [7:0] meta_a = '0, meta_b = '0;
  logic       full_a, full_b;
`ifdef BEAM_META_CAPTURE_DROPS_EN
  logic [15:0] drop_a, drop_b;
`endif

  int tests = 0;
  int fails = 0;
  int t = 0;

  beam_meta_capture_if if_a ();
  beam_meta_capture_if if_b ();

  beam_meta_capture #(.TS_BITS(24), .DEPTH(16), .HOLDOFF(8)) u_a (
    .clk_i (clk), .rst_i (rst), .run_i (run), .trig_i (trig_a), .meta_i (meta_a),
    .m (if_a), .full_o (full_a)
`ifdef BEAM_META_CAPTURE_DROPS_EN
    , .drop_count_o (drop_a)
`endif
  );

  beam_meta_capture #(.TS_BITS(8), .DEPTH(16), .HOLDOFF(0)) u_b (
    .clk_i (clk), .rst_i (rst), .run_i (run), .trig_i (trig_b), .meta_i (meta_b),
    .m (if_b), .full_o (full_b)
`ifdef BEAM_META_CAPTURE_DROPS_EN
    , .drop_count_o (drop_b)
`endif
  );

  always #5 clk = ~clk;

  // After tick, t equals the DUT timestamp of the cycle now being driven.
  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic tick_to(input int n);
    while (t < n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    trig_a = 1'b0; trig_b = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    t = 0;
  endtask

  task automatic test_reset();
    if_a.m_tready = 1'b0;
    if_b.m_tready = 1'b0;
    do_reset();
    tests++;
    if (if_a.m_tvalid !== 1'b0 || if_a.m_tdata !== 32'h0 || full_a !== 1'b0) begin
      fails++;
      $display("FAIL reset_a: valid=%b data=%h full=%b want 0/0/0", if_a.m_tvalid, if_a.m_tdata, full_a);
    end
    tests++;
    if (if_b.m_tvalid !== 1'b0 || if_b.m_tdata !== 32'h0 || full_b !== 1'b0) begin
      fails++;
      $display("FAIL reset_b: valid=%b data=%h full=%b want 0/0/0", if_b.m_tvalid, if_b.m_tdata, full_b);
    end
`ifdef BEAM_META_CAPTURE_DROPS_EN
    tests++;
    if (drop_a !== 16'h0 || drop_b !== 16'h0) begin
      fails++;
      $display("FAIL reset_drops: a=%h b=%h want 0", drop_a, drop_b);
    end
`endif
  endtask

  task automatic test_basic();
    do_reset();
    run = 1'b1;
    if_a.m_tready = 1'b1;
    tick_to(50);
    run = 1'b0; trig_a = 1'b1; meta_a = 8'h3C;
    tick();
    trig_a = 1'b0; run = 1'b1;
    tests++;
    if (if_a.m_tvalid !== 1'b0) begin
      fails++;
      $display("FAIL run_low_ignored: valid=%b want 0", if_a.m_tvalid);
    end
    tick_to(100);
    trig_a = 1'b1; meta_a = 8'hA5;
    tick();
    trig_a = 1'b0;
    tests++;
    if (if_a.m_tvalid !== 1'b1 || if_a.m_tdata !== 32'hA500_0064) begin
      fails++;
      $display("FAIL basic_record: valid=%b data=%h want 1/a5000064", if_a.m_tvalid, if_a.m_tdata);
    end
    tick();
    tests++;
    if (if_a.m_tvalid !== 1'b0) begin
      fails++;
      $display("FAIL basic_one_cycle: valid=%b want 0", if_a.m_tvalid);
    end
  endtask

  task automatic test_holdoff();
    do_reset();
    if_a.m_tready = 1'b0;
    tick_to(10); trig_a = 1'b1; meta_a = 8'h11; tick(); trig_a = 1'b0;
    tick_to(12); trig_a = 1'b1; meta_a = 8'h22; tick(); trig_a = 1'b0;
    tick_to(18); trig_a = 1'b1; meta_a = 8'h33; tick();
    meta_a = 8'h44; tick(); trig_a = 1'b0;
    tests++;
    if (if_a.m_tvalid !== 1'b1 || if_a.m_tdata !== 32'h1100_000A) begin
      fails++;
      $display("FAIL holdoff_first: valid=%b data=%h want 1/1100000a", if_a.m_tvalid, if_a.m_tdata);
    end
    if_a.m_tready = 1'b1;
    tick();
    tests++;
    if (if_a.m_tvalid !== 1'b1 || if_a.m_tdata !== 32'h4400_0013) begin
      fails++;
      $display("FAIL holdoff_second: valid=%b data=%h want 1/44000013", if_a.m_tvalid, if_a.m_tdata);
    end
    tick();
    tests++;
    if (if_a.m_tvalid !== 1'b0) begin
      fails++;
      $display("FAIL holdoff_count: valid=%b want 0 (extra record)", if_a.m_tvalid);
    end
`ifdef BEAM_META_CAPTURE_DROPS_EN
    tests++;
    if (drop_a !== 16'h0) begin
      fails++;
      $display("FAIL holdoff_no_drop: drops=%h want 0", drop_a);
    end
`endif
  endtask

  task automatic test_full_drops();
    logic [31:0] exp;
    do_reset();
    if_b.m_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      trig_b = 1'b1; meta_b = 8'h40 + 8'(i);
      tick();
      if (i == 14) begin
        tests++;
        if (full_b !== 1'b0) begin
          fails++;
          $display("FAIL full_at_15: full=%b want 0", full_b);
        end
      end
      if (i == 15) begin
        tests++;
        if (full_b !== 1'b1) begin
          fails++;
          $display("FAIL full_at_16: full=%b want 1", full_b);
        end
      end
    end
    trig_b = 1'b0;
`ifdef BEAM_META_CAPTURE_DROPS_EN
    tests++;
    if (drop_b !== 16'd4) begin
      fails++;
      $display("FAIL drops_4: drops=%0d want 4", drop_b);
    end
`endif
    tests++;
    if (if_b.m_tvalid !== 1'b1 || if_b.m_tdata !== 32'h4000_0000) begin
      fails++;
      $display("FAIL drain_0: valid=%b data=%h want 1/40000000", if_b.m_tvalid, if_b.m_tdata);
    end
    // Trigger and pop in the same cycle while full.
    if_b.m_tready = 1'b1; trig_b = 1'b1; meta_b = 8'hEE;
    tick();
    trig_b = 1'b0;
    tests++;
    if (full_b !== 1'b0 || if_b.m_tdata !== 32'h4100_0001) begin
      fails++;
      $display("FAIL push_pop_full: full=%b data=%h want 0/41000001", full_b, if_b.m_tdata);
    end
`ifdef BEAM_META_CAPTURE_DROPS_EN
    tests++;
    if (drop_b !== 16'd5) begin
      fails++;
      $display("FAIL drops_5: drops=%0d want 5", drop_b);
    end
`endif
    for (int k = 2; k < 16; k++) begin
      tick();
      exp = {8'h40 + 8'(k), 24'(k)};
      tests++;
      if (if_b.m_tvalid !== 1'b1 || if_b.m_tdata !== exp) begin
        fails++;
        $display("FAIL drain_%0d: valid=%b data=%h want 1/%h", k, if_b.m_tvalid, if_b.m_tdata, exp);
      end
    end
    tick();
    tests++;
    if (if_b.m_tvalid !== 1'b0) begin
      fails++;
      $display("FAIL drain_empty: valid=%b data=%h want 0", if_b.m_tvalid, if_b.m_tdata);
    end
  endtask

  task automatic test_wrap_backpressure();
    logic [31:0] exp;
    do_reset();
    if_b.m_tready = 1'b0;
    tick_to(255); trig_b = 1'b1; meta_b = 8'h5A; tick(); trig_b = 1'b0;
    tick_to(257); trig_b = 1'b1; meta_b = 8'h5B; tick(); trig_b = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if_b.m_tready = (k % 3 == 2);
      exp = (k < 3) ? 32'h5A00_00FF : 32'h5B00_0001;
      tests++;
      if (if_b.m_tvalid !== 1'b1 || if_b.m_tdata !== exp) begin
        fails++;
        $display("FAIL wrap_bp_%0d: valid=%b data=%h want 1/%h", k, if_b.m_tvalid, if_b.m_tdata, exp);
      end
      tick();
    end
    if_b.m_tready = 1'b0;
    tests++;
    if (if_b.m_tvalid !== 1'b0) begin
      fails++;
      $display("FAIL wrap_empty: valid=%b want 0", if_b.m_tvalid);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    if_b.m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      trig_b = 1'b1; meta_b = 8'h60 + 8'(i);
      tick();
    end
    trig_b = 1'b0;
    tests++;
    if (if_b.m_tvalid !== 1'b1 || if_b.m_tdata !== 32'h6000_0000) begin
      fails++;
      $display("FAIL queued_5: valid=%b data=%h want 1/60000000", if_b.m_tvalid, if_b.m_tdata);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (if_b.m_tvalid !== 1'b0 || if_b.m_tdata !== 32'h0) begin
      fails++;
      $display("FAIL async_clear: valid=%b data=%h want 0/0", if_b.m_tvalid, if_b.m_tdata);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    t = 0;
`ifdef BEAM_META_CAPTURE_DROPS_EN
    tests++;
    if (drop_b !== 16'h0) begin
      fails++;
      $display("FAIL reset_drop_clear: drops=%h want 0", drop_b);
    end
`endif
    tick_to(3);
    trig_b = 1'b1; meta_b = 8'h77;
    tick();
    trig_b = 1'b0;
    tests++;
    if (if_b.m_tvalid !== 1'b1 || if_b.m_tdata !== 32'h7700_0003) begin
      fails++;
      $display("FAIL post_reset_ts: valid=%b data=%h want 1/77000003", if_b.m_tvalid, if_b.m_tdata);
    end
    tick();
    tests++;
    if (if_b.m_tvalid !== 1'b1 || if_b.m_tdata !== 32'h7700_0003) begin
      fails++;
      $display("FAIL post_reset_only: valid=%b data=%h want 1/77000003", if_b.m_tvalid, if_b.m_tdata);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_holdoff();
    test_full_drops();
    test_wrap_backpressure();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
